// File: rtl/spi_display_rx.sv
// SPI-fed 8-digit multiplexed LED display controller (MAX7219-style register map).
// SPI pins are synchronized into clk; committed words drive a PWM-dimmed digit scan.
module spi_display_rx #(
    parameter int PWM_STEP = 64
) (
    input  logic       clk,
    input  logic       res,
    input  logic       cs_in,
    input  logic       sck,
    input  logic       mosi,
    output logic [7:0] seg_out,
    output logic [7:0] dig_sel,
    output logic       word_valid,
    output logic       frame_err
);

    localparam int SW = (PWM_STEP > 1) ? $clog2(PWM_STEP) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(PWM_STEP - 1);

    typedef enum logic {
        RX_IDLE  = 1'b0,
        RX_FRAME = 1'b1
    } rx_state_t;

    // Code B font: 0-9, '-', 'E', 'H', 'L', 'P', blank
    function automatic logic [6:0] code_b(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h7E;
            4'h1:    s = 7'h30;
            4'h2:    s = 7'h6D;
            4'h3:    s = 7'h79;
            4'h4:    s = 7'h33;
            4'h5:    s = 7'h5B;
            4'h6:    s = 7'h5F;
            4'h7:    s = 7'h70;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h7B;
            4'hA:    s = 7'h01;
            4'hB:    s = 7'h4F;
            4'hC:    s = 7'h37;
            4'hD:    s = 7'h0E;
            4'hE:    s = 7'h67;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic            cs_s1_q, cs_s2_q, cs_s3_q;
    logic            sck_s1_q, sck_s2_q, sck_s3_q;
    logic            mosi_s1_q, mosi_s2_q, mosi_bit_q;
    logic [2:0]      vld_q;
    logic            cs_fall_q, cs_rise_q, sck_rise_q;
    logic            cs_fall_d, cs_rise_d, sck_rise_d;
    rx_state_t       rx_state_q, rx_state_d;
    logic [4:0]      bit_cnt_q, bit_cnt_d;
    logic [15:0]     shift_q, shift_d;
    logic [7:0]      dig_q [8];
    logic [7:0]      dig_d [8];
    logic [7:0]      decode_q, decode_d;
    logic [3:0]      intens_q, intens_d;
    logic [2:0]      scan_q, scan_d;
    logic            shut_q, shut_d;
    logic            test_q, test_d;
    logic [SW-1:0]   step_q, step_d;
    logic [3:0]      phase_q, phase_d;
    logic [2:0]      index_q, index_d;
    logic [7:0]      seg_q, seg_d;
    logic [7:0]      dsel_q, dsel_d;
    logic            wv_q, wv_d;
    logic            fe_q, fe_d;
    logic [2:0]      widx_s;
    logic [2:0]      limit_s;
    logic            lit_s;

    // Edge pulses; vld_q masks edges that would compare against reset-idle pipeline contents
    always_comb begin
        cs_fall_d  = vld_q[2] & cs_s3_q & ~cs_s2_q;
        cs_rise_d  = vld_q[2] & ~cs_s3_q & cs_s2_q;
        sck_rise_d = vld_q[2] & ~sck_s3_q & sck_s2_q;
    end

    // Receiver FSM and register file update
    always_comb begin
        rx_state_d = rx_state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        dig_d      = dig_q;
        decode_d   = decode_q;
        intens_d   = intens_q;
        scan_d     = scan_q;
        shut_d     = shut_q;
        test_d     = test_q;
        wv_d       = 1'b0;
        fe_d       = 1'b0;
        widx_s     = shift_q[10:8] - 3'd1;
        case (rx_state_q)
            RX_IDLE: begin
                if (cs_fall_q) begin
                    rx_state_d = RX_FRAME;
                    bit_cnt_d  = 5'd0;
                end else begin
                    rx_state_d = RX_IDLE;
                end
            end
            RX_FRAME: begin
                if (cs_rise_q) begin
                    rx_state_d = RX_IDLE;
                    if (bit_cnt_q == 5'd16) begin
                        wv_d = 1'b1;
                        case (shift_q[11:8])
                            4'h1, 4'h2, 4'h3, 4'h4,
                            4'h5, 4'h6, 4'h7, 4'h8: dig_d[widx_s] = shift_q[7:0];
                            4'h9:    decode_d = shift_q[7:0];
                            4'hA:    intens_d = shift_q[3:0];
                            4'hB:    scan_d   = shift_q[2:0];
                            4'hC:    shut_d   = shift_q[0];
                            4'hF:    test_d   = shift_q[0];
                            default: test_d   = test_q;
                        endcase
                    end else begin
                        fe_d = 1'b1;
                    end
                end else if (sck_rise_q) begin
                    shift_d   = {shift_q[14:0], mosi_bit_q};
                    bit_cnt_d = (bit_cnt_q == 5'd16) ? 5'd16 : bit_cnt_q + 5'd1;
                end else begin
                    rx_state_d = RX_FRAME;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Digit slot timing and scan index; display test forces a full 8-digit scan
    always_comb begin
        step_d  = step_q;
        phase_d = phase_q;
        index_d = index_q;
        limit_s = test_q ? 3'd7 : scan_q;
        if (step_q == STEP_LAST) begin
            step_d  = '0;
            phase_d = phase_q + 4'd1;
            if (phase_q == 4'd15) begin
                index_d = (index_q >= limit_s) ? 3'd0 : index_q + 3'd1;
            end else begin
                index_d = index_q;
            end
        end else begin
            step_d = step_q + SW'(1);
        end
    end

    // Segment and digit drive for the current slot and phase
    always_comb begin
        seg_d  = 8'h00;
        dsel_d = 8'h00;
        lit_s  = test_q | (shut_q & (phase_q <= intens_q));
        if (lit_s) begin
            dsel_d = 8'b1 << index_q;
            if (test_q) begin
                seg_d = 8'hFF;
            end else if (decode_q[index_q]) begin
                seg_d = {dig_q[index_q][7], code_b(dig_q[index_q][3:0])};
            end else begin
                seg_d = dig_q[index_q];
            end
        end else begin
            seg_d  = 8'h00;
            dsel_d = 8'h00;
        end
    end

    // State registers; res overrides every event in the same cycle
    always_ff @(posedge clk) begin
        if (res) begin
            cs_s1_q    <= 1'b1;
            cs_s2_q    <= 1'b1;
            cs_s3_q    <= 1'b1;
            sck_s1_q   <= 1'b0;
            sck_s2_q   <= 1'b0;
            sck_s3_q   <= 1'b0;
            mosi_s1_q  <= 1'b0;
            mosi_s2_q  <= 1'b0;
            mosi_bit_q <= 1'b0;
            vld_q      <= 3'b000;
            cs_fall_q  <= 1'b0;
            cs_rise_q  <= 1'b0;
            sck_rise_q <= 1'b0;
            rx_state_q <= RX_IDLE;
            bit_cnt_q  <= 5'd0;
            shift_q    <= 16'h0000;
            for (int i = 0; i < 8; i++) begin
                dig_q[i] <= 8'h00;
            end
            decode_q   <= 8'h00;
            intens_q   <= 4'h0;
            scan_q     <= 3'd0;
            shut_q     <= 1'b0;
            test_q     <= 1'b0;
            step_q     <= '0;
            phase_q    <= 4'd0;
            index_q    <= 3'd0;
            seg_q      <= 8'h00;
            dsel_q     <= 8'h00;
            wv_q       <= 1'b0;
            fe_q       <= 1'b0;
        end else begin
            cs_s1_q    <= cs_in;
            cs_s2_q    <= cs_s1_q;
            cs_s3_q    <= cs_s2_q;
            sck_s1_q   <= sck;
            sck_s2_q   <= sck_s1_q;
            sck_s3_q   <= sck_s2_q;
            mosi_s1_q  <= mosi;
            mosi_s2_q  <= mosi_s1_q;
            mosi_bit_q <= mosi_s2_q;
            vld_q      <= {vld_q[1:0], 1'b1};
            cs_fall_q  <= cs_fall_d;
            cs_rise_q  <= cs_rise_d;
            sck_rise_q <= sck_rise_d;
            rx_state_q <= rx_state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            dig_q      <= dig_d;
            decode_q   <= decode_d;
            intens_q   <= intens_d;
            scan_q     <= scan_d;
            shut_q     <= shut_d;
            test_q     <= test_d;
            step_q     <= step_d;
            phase_q    <= phase_d;
            index_q    <= index_d;
            seg_q      <= seg_d;
            dsel_q     <= dsel_d;
            wv_q       <= wv_d;
            fe_q       <= fe_d;
        end
    end

    assign seg_out    = seg_q;
    assign dig_sel    = dsel_q;
    assign word_valid = wv_q;
    assign frame_err  = fe_q;

endmodule

// File: tb/tb_spi_display_rx.sv
// Directed bench for spi_display_rx: vector table of SPI words plus scan/PWM/reset sequences.
module tb_spi_display_rx;

    localparam int PS   = 4;
    localparam int SLOT = 16 * PS;

    logic       clk = 1'b0;
    logic       res, cs_in, sck, mosi;
    logic [7:0] seg_out, dig_sel;
    logic       word_valid, frame_err;

    int n_vec  = 0;
    int n_err  = 0;
    int wv_cnt = 0;
    int fe_cnt = 0;

    spi_display_rx #(.PWM_STEP(PS)) dut (
        .clk(clk), .res(res), .cs_in(cs_in), .sck(sck), .mosi(mosi),
        .seg_out(seg_out), .dig_sel(dig_sel),
        .word_valid(word_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (word_valid) wv_cnt++;
        if (frame_err)  fe_cnt++;
    end

    typedef struct {
        logic [31:0] word;
        int          nbits;
        int          wv;
        int          fe;
        bit          stat;
        logic [7:0]  dig;
        logic [7:0]  seg;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic shift_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = v[i];
            repeat (4) @(negedge clk);
            sck = 1'b1;
            repeat (4) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic send(input logic [31:0] v, input int n, input bit raise);
        cs_in = 1'b0;
        repeat (4) @(negedge clk);
        shift_bits(v, n);
        repeat (4) @(negedge clk);
        if (raise) begin
            cs_in = 1'b1;
            repeat (12) @(negedge clk);
        end
    endtask

    task automatic check_static(input string nm, input logic [7:0] d, input logic [7:0] s);
        int bad = 0;
        logic [7:0] bd = 8'h00;
        logic [7:0] bs = 8'h00;
        repeat (2 * SLOT) begin
            @(negedge clk);
            if (dig_sel !== d || seg_out !== s) begin
                if (bad == 0) begin
                    bd = dig_sel;
                    bs = seg_out;
                end
                bad++;
            end
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL %s: %0d bad samples, first dig_sel=%h seg_out=%h, required dig_sel=%h seg_out=%h",
                     nm, bad, bd, bs, d, s);
        end
    endtask

    task automatic wait_change(input string nm, input logic [7:0] from, input logic [7:0] to,
                               input int bound);
        logic [7:0] prev;
        bit ok = 1'b0;
        prev = dig_sel;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (prev === from && dig_sel === to) begin
                ok = 1'b1;
                break;
            end
            prev = dig_sel;
        end
        chk(nm, int'(ok), 1);
    endtask

    task automatic measure_run(input logic [7:0] exp_seg, output logic [7:0] v,
                               output int len, output int bad);
        v   = dig_sel;
        len = 0;
        bad = 0;
        while (dig_sel === v && len < 1000) begin
            if (seg_out !== exp_seg) bad++;
            len++;
            @(negedge clk);
        end
    endtask

    initial begin
        int wv0, fe0, len, bad, k_hit;
        logic [7:0] v;
        logic [7:0] ev;

        tbl[0]  = '{32'h0C01, 16, 1, 0, 1'b0, 8'h00, 8'h00};
        tbl[1]  = '{32'h0B00, 16, 1, 0, 1'b0, 8'h00, 8'h00};
        tbl[2]  = '{32'h0A0F, 16, 1, 0, 1'b1, 8'h01, 8'h00};
        tbl[3]  = '{32'h0901, 16, 1, 0, 1'b1, 8'h01, 8'h7E};
        tbl[4]  = '{32'h0105, 16, 1, 0, 1'b1, 8'h01, 8'h5B};
        tbl[5]  = '{32'h0185, 16, 1, 0, 1'b1, 8'h01, 8'hDB};
        tbl[6]  = '{32'h0C00, 16, 1, 0, 1'b1, 8'h00, 8'h00};
        tbl[7]  = '{32'h0C01, 12, 0, 1, 1'b1, 8'h00, 8'h00};
        tbl[8]  = '{32'hA0C01, 20, 1, 0, 1'b1, 8'h01, 8'hDB};
        tbl[9]  = '{32'h0D55, 16, 1, 0, 1'b1, 8'h01, 8'hDB};
        tbl[10] = '{32'h0000, 16, 1, 0, 1'b1, 8'h01, 8'hDB};
        tbl[11] = '{32'h5103, 16, 1, 0, 1'b1, 8'h01, 8'h79};
        tbl[12] = '{32'h010C, 16, 1, 0, 1'b1, 8'h01, 8'h37};
        tbl[13] = '{32'h0900, 16, 1, 0, 1'b1, 8'h01, 8'h0C};

        res = 1'b1; cs_in = 1'b1; sck = 1'b0; mosi = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset seg_out", int'(seg_out), 0);
        chk("reset dig_sel", int'(dig_sel), 0);
        chk("reset word_valid", int'(word_valid), 0);
        chk("reset frame_err", int'(frame_err), 0);
        res = 1'b0;
        repeat (4) @(negedge clk);

        // commit latency: word_valid on the 4th posedge after cs_in rises
        wv0 = wv_cnt;
        send(32'h0000, 16, 1'b0);
        cs_in = 1'b1;
        k_hit = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (word_valid === 1'b1 && k_hit == 0) k_hit = k;
        end
        chk("commit latency edges", k_hit, 4);
        chk("latency word_valid count", wv_cnt - wv0, 1);

        for (int i = 0; i < 14; i++) begin
            wv0 = wv_cnt;
            fe0 = fe_cnt;
            send(tbl[i].word, tbl[i].nbits, 1'b1);
            chk($sformatf("vec%0d word_valid pulses", i), wv_cnt - wv0, tbl[i].wv);
            chk($sformatf("vec%0d frame_err pulses", i), fe_cnt - fe0, tbl[i].fe);
            if (tbl[i].stat) check_static($sformatf("vec%0d display", i), tbl[i].dig, tbl[i].seg);
        end

        // two-digit scan: each digit holds for one full slot
        send(32'h0100, 16, 1'b1);
        send(32'h0280, 16, 1'b1);
        send(32'h0B01, 16, 1'b1);
        wait_change("scan2 sync", 8'h01, 8'h02, 4 * SLOT);
        measure_run(8'h80, v, len, bad);
        chk("scan2 digit2 dig_sel", int'(v), 8'h02);
        chk("scan2 digit2 length", len, SLOT);
        chk("scan2 digit2 seg", bad, 0);
        measure_run(8'h00, v, len, bad);
        chk("scan2 digit1 dig_sel", int'(v), 8'h01);
        chk("scan2 digit1 length", len, SLOT);
        chk("scan2 digit1 seg", bad, 0);

        // intensity 3: lit for phases 0..3 of each slot
        send(32'h0B00, 16, 1'b1);
        send(32'h0A03, 16, 1'b1);
        wait_change("pwm sync", 8'h00, 8'h01, 4 * SLOT);
        measure_run(8'h00, v, len, bad);
        chk("pwm lit dig_sel", int'(v), 8'h01);
        chk("pwm lit length", len, 4 * PS);
        chk("pwm lit seg", bad, 0);
        measure_run(8'h00, v, len, bad);
        chk("pwm dark dig_sel", int'(v), 8'h00);
        chk("pwm dark length", len, 12 * PS);

        // display test while shut down: full 8-digit scan, all segments on
        send(32'h0C00, 16, 1'b1);
        send(32'h0F01, 16, 1'b1);
        wait_change("test sync", 8'h80, 8'h01, 12 * SLOT);
        for (int k = 0; k < 8; k++) begin
            measure_run(8'hFF, v, len, bad);
            ev = 8'h01 << k;
            chk($sformatf("test digit%0d dig_sel", k), int'(v), int'(ev));
            chk($sformatf("test digit%0d length", k), len, SLOT);
            chk($sformatf("test digit%0d seg", k), bad, 0);
        end
        send(32'h0F00, 16, 1'b1);
        check_static("test off shutdown", 8'h00, 8'h00);

        // reset mid-frame with cs_in held low across the reset
        send(32'h0F01, 16, 1'b1);
        send(32'h00FF, 8, 1'b0);
        res = 1'b1;
        repeat (2) @(negedge clk);
        res = 1'b0;
        wv0 = wv_cnt;
        fe0 = fe_cnt;
        shift_bits(32'h0F01, 16);
        repeat (4) @(negedge clk);
        cs_in = 1'b1;
        repeat (12) @(negedge clk);
        chk("midreset word_valid pulses", wv_cnt - wv0, 0);
        chk("midreset frame_err pulses", fe_cnt - fe0, 0);
        check_static("midreset display", 8'h00, 8'h00);
        send(32'h0F01, 16, 1'b1);
        chk("post-reset test seg_out", int'(seg_out), 8'hFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
